// File: rtl/servo_pkg.sv
// Shared widths, coefficient addresses and sequencer state encoding
// for the servo coefficient sequencer.
package servo_pkg;

  localparam int COEF_W   = 35;
  localparam int NUM_COEF = 6;

  localparam logic [2:0] ADDR_A1_PI = 3'd0;
  localparam logic [2:0] ADDR_B0_PI = 3'd1;
  localparam logic [2:0] ADDR_B1_PI = 3'd2;
  localparam logic [2:0] ADDR_A1_PD = 3'd3;
  localparam logic [2:0] ADDR_B0_PD = 3'd4;
  localparam logic [2:0] ADDR_B1_PD = 3'd5;

  typedef logic [NUM_COEF-1:0][COEF_W-1:0] coef_vec_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MUTE   = 2'd1,
    APPLY  = 2'd2,
    RESUME = 2'd3
  } seq_state_t;

  function automatic logic addr_valid(input logic [2:0] addr);
    return addr < 3'(NUM_COEF);
  endfunction

endpackage

// File: rtl/servo_coef_bank.sv
// Shadow/active coefficient storage: single-word writes go to the shadow
// bank, and one copy pulse moves all six shadows to the active bank at once.
module servo_coef_bank
  import servo_pkg::*;
(
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     wr_en_in,
  input  logic [2:0]               wr_addr_in,
  input  logic signed [COEF_W-1:0] wr_data_in,
  input  logic                     copy_in,
  output coef_vec_t                active_out
);

  coef_vec_t shadow_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      shadow_q <= '0;
    end else if (wr_en_in) begin
      for (int i = 0; i < NUM_COEF; i++) begin
        if (wr_addr_in == 3'(i)) begin
          shadow_q[i] <= wr_data_in;
        end
      end
    end
  end

  // Whole-bank copy so the filters never see a mix of old and new coefficients.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      active_out <= '0;
    end else if (copy_in) begin
      active_out <= shadow_q;
    end
  end

endmodule

// File: rtl/servo_coef_sequencer.sv
// Commit sequencer for the PI/PD servo coefficients: mute, flush, atomic apply.
// Optional readback port enabled by defining SERVO_COEF_READBACK_EN.
module servo_coef_sequencer
  import servo_pkg::*;
#(
  parameter int FLUSH_CYCLES   = 4,
  parameter int MUTE_ON_COMMIT = 1
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     wr_valid_in,
  output logic                     wr_ready_out,
  input  logic [2:0]               wr_addr_in,
  input  logic signed [COEF_W-1:0] wr_data_in,
  input  logic                     commit_in,
  input  logic                     servo_en_in,
  output logic                     on_out,
  output logic signed [COEF_W-1:0] a1_PI_out,
  output logic signed [COEF_W-1:0] b0_PI_out,
  output logic signed [COEF_W-1:0] b1_PI_out,
  output logic signed [COEF_W-1:0] a1_PD_out,
  output logic signed [COEF_W-1:0] b0_PD_out,
  output logic signed [COEF_W-1:0] b1_PD_out,
  output logic                     busy_out,
  output logic                     err_out
`ifdef SERVO_COEF_READBACK_EN
  ,
  input  logic [2:0]               rd_addr_in,
  output logic signed [COEF_W-1:0] rd_data_out
`endif
);

  seq_state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       wr_fire;
  logic       copy_en;
  coef_vec_t  active;

  assign wr_ready_out = (state_q == IDLE);
  assign busy_out     = ~wr_ready_out;
  assign wr_fire      = wr_valid_in & wr_ready_out;

  // The counter is loaded on entry to MUTE and the exit is taken on the edge
  // it reaches zero, so APPLY starts FLUSH_CYCLES edges after the commit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    copy_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (commit_in) begin
          if (MUTE_ON_COMMIT != 0) begin
            state_d = MUTE;
            cnt_d   = 8'(FLUSH_CYCLES);
          end else begin
            state_d = APPLY;
          end
        end
      end
      MUTE: begin
        if (cnt_q <= 8'd1) begin
          state_d = APPLY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      APPLY: begin
        copy_en = 1'b1;
        state_d = RESUME;
      end
      RESUME: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      on_out  <= 1'b0;
      err_out <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      on_out  <= (state_d == MUTE) ? 1'b0 : servo_en_in;
      err_out <= wr_fire & ~addr_valid(wr_addr_in);
    end
  end

  servo_coef_bank u_bank (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .wr_en_in   (wr_fire & addr_valid(wr_addr_in)),
    .wr_addr_in (wr_addr_in),
    .wr_data_in (wr_data_in),
    .copy_in    (copy_en),
    .active_out (active)
  );

  assign a1_PI_out = active[ADDR_A1_PI];
  assign b0_PI_out = active[ADDR_B0_PI];
  assign b1_PI_out = active[ADDR_B1_PI];
  assign a1_PD_out = active[ADDR_A1_PD];
  assign b0_PD_out = active[ADDR_B0_PD];
  assign b1_PD_out = active[ADDR_B1_PD];

`ifdef SERVO_COEF_READBACK_EN
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rd_data_out <= '0;
    end else begin
      rd_data_out <= addr_valid(rd_addr_in) ? active[rd_addr_in] : '0;
    end
  end
`endif

endmodule

// File: tb/tb_servo_coef_sequencer.sv
// Bench for servo_coef_sequencer: a muted (FLUSH=4) and an unmuted instance
// share stimulus and are each compared every cycle against a countdown model.
`timescale 1ns/1ps
module tb_servo_coef_sequencer;
  import servo_pkg::*;

  localparam int FLUSH = 4;
  localparam int NDUT  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic                     wr_valid = 1'b0;
  logic [2:0]               wr_addr  = '0;
  logic signed [COEF_W-1:0] wr_data  = '0;
  logic                     commit   = 1'b0;
  logic                     servo_en = 1'b0;

  logic [NDUT-1:0] ready_o, busy_o, err_o, on_o;
  logic [NDUT-1:0][NUM_COEF-1:0][COEF_W-1:0] coef_o;
`ifdef SERVO_COEF_READBACK_EN
  logic [2:0] rd_addr = '0;
  logic [NDUT-1:0][COEF_W-1:0] rd_o;
`endif

  always #5 clk = ~clk;

  servo_coef_sequencer #(.FLUSH_CYCLES(FLUSH), .MUTE_ON_COMMIT(1)) dut_mute (
    .clk_in(clk), .rst_n_in(rst_n),
    .wr_valid_in(wr_valid), .wr_ready_out(ready_o[0]),
    .wr_addr_in(wr_addr), .wr_data_in(wr_data),
    .commit_in(commit), .servo_en_in(servo_en), .on_out(on_o[0]),
    .a1_PI_out(coef_o[0][0]), .b0_PI_out(coef_o[0][1]), .b1_PI_out(coef_o[0][2]),
    .a1_PD_out(coef_o[0][3]), .b0_PD_out(coef_o[0][4]), .b1_PD_out(coef_o[0][5]),
    .busy_out(busy_o[0]), .err_out(err_o[0])
`ifdef SERVO_COEF_READBACK_EN
    , .rd_addr_in(rd_addr), .rd_data_out(rd_o[0])
`endif
  );

  servo_coef_sequencer #(.FLUSH_CYCLES(FLUSH), .MUTE_ON_COMMIT(0)) dut_nomute (
    .clk_in(clk), .rst_n_in(rst_n),
    .wr_valid_in(wr_valid), .wr_ready_out(ready_o[1]),
    .wr_addr_in(wr_addr), .wr_data_in(wr_data),
    .commit_in(commit), .servo_en_in(servo_en), .on_out(on_o[1]),
    .a1_PI_out(coef_o[1][0]), .b0_PI_out(coef_o[1][1]), .b1_PI_out(coef_o[1][2]),
    .a1_PD_out(coef_o[1][3]), .b0_PD_out(coef_o[1][4]), .b1_PD_out(coef_o[1][5]),
    .busy_out(busy_o[1]), .err_out(err_o[1])
`ifdef SERVO_COEF_READBACK_EN
    , .rd_addr_in(rd_addr), .rd_data_out(rd_o[1])
`endif
  );

  // Model: a commit starts a busy countdown of seqLength cycles; the mute
  // window is while more than 2 cycles remain, the copy lands when 1 remains.
  logic signed [COEF_W-1:0] shadow_m [NDUT][NUM_COEF];
  logic signed [COEF_W-1:0] active_m [NDUT][NUM_COEF];
  logic signed [COEF_W-1:0] rd_m     [NDUT];
  int busy_left [NDUT];
  bit err_m [NDUT];
  bit on_m  [NDUT];

  int checks = 0;
  int failures = 0;
  int busyCount [NDUT];
  int onLowCount [NDUT];

  function automatic int seqLength(input int d);
    return (d == 0) ? FLUSH + 2 : 2;
  endfunction

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    for (int d = 0; d < NDUT; d++) begin
      for (int i = 0; i < NUM_COEF; i++) begin
        shadow_m[d][i] = '0;
        active_m[d][i] = '0;
      end
      rd_m[d] = '0;
      busy_left[d] = 0;
      err_m[d] = 1'b0;
      on_m[d] = 1'b0;
    end
  endtask

  task automatic modelEdge();
    if (!rst_n) return;
    for (int d = 0; d < NDUT; d++) begin
`ifdef SERVO_COEF_READBACK_EN
      rd_m[d] = (rd_addr < 3'd6) ? active_m[d][rd_addr] : '0;
`endif
      err_m[d] = 1'b0;
      if (busy_left[d] == 0) begin
        if (wr_valid) begin
          if (wr_addr < 3'd6) shadow_m[d][wr_addr] = wr_data;
          else err_m[d] = 1'b1;
        end
        if (commit) busy_left[d] = seqLength(d);
      end else begin
        busy_left[d]--;
        if (busy_left[d] == 1) active_m[d] = shadow_m[d];
      end
      on_m[d] = (busy_left[d] > 2) ? 1'b0 : servo_en;
    end
  endtask

  task automatic compareAll(input string tag);
    for (int d = 0; d < NDUT; d++) begin
      checkOutput($sformatf("%s.d%0d.ready", tag, d), longint'(ready_o[d]), longint'(busy_left[d] == 0));
      checkOutput($sformatf("%s.d%0d.busy", tag, d), longint'(busy_o[d]), longint'(busy_left[d] != 0));
      checkOutput($sformatf("%s.d%0d.err", tag, d), longint'(err_o[d]), longint'(err_m[d]));
      checkOutput($sformatf("%s.d%0d.on", tag, d), longint'(on_o[d]), longint'(on_m[d]));
      for (int i = 0; i < NUM_COEF; i++) begin
        checkOutput($sformatf("%s.d%0d.coef%0d", tag, d, i),
                    longint'($signed(coef_o[d][i])), longint'(active_m[d][i]));
      end
`ifdef SERVO_COEF_READBACK_EN
      checkOutput($sformatf("%s.d%0d.rd", tag, d), longint'($signed(rd_o[d])), longint'(rd_m[d]));
`endif
    end
  endtask

  task automatic stepCycle(input string tag);
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    compareAll(tag);
    for (int d = 0; d < NDUT; d++) begin
      if (busy_o[d]) busyCount[d]++;
      if (!on_o[d]) onLowCount[d]++;
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] a,
                               input logic signed [COEF_W-1:0] dat,
                               input logic c, input logic en, input string tag);
    wr_valid = v;
    wr_addr  = a;
    wr_data  = dat;
    commit   = c;
    servo_en = en;
    stepCycle(tag);
  endtask

  task automatic clearCounts();
    for (int d = 0; d < NDUT; d++) begin
      busyCount[d] = 0;
      onLowCount[d] = 0;
    end
  endtask

  task automatic settle(input int n, input string tag);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 3'd0, '0, 1'b0, 1'b1, tag);
  endtask

  initial begin
    modelReset();
    clearCounts();
    @(negedge clk);
    compareAll("reset");
    rst_n = 1'b1;

    // Load 1..6 then commit: 6 busy cycles / 4 muted cycles vs 2 / 0.
    settle(2, "pre");
    for (int i = 0; i < NUM_COEF; i++)
      applyStimulus(1'b1, 3'(i), COEF_W'(i + 1), 1'b0, 1'b1, "load");
    clearCounts();
    applyStimulus(1'b0, 3'd0, '0, 1'b1, 1'b1, "commit");
    settle(8, "apply");
    checkOutput("busy_len_mute", busyCount[0], 6);
    checkOutput("busy_len_nomute", busyCount[1], 2);
    checkOutput("on_low_mute", onLowCount[0], 4);
    checkOutput("on_low_nomute", onLowCount[1], 0);
    for (int i = 0; i < NUM_COEF; i++)
      checkOutput($sformatf("loaded_coef%0d", i), longint'($signed(coef_o[0][i])), i + 1);

    // Illegal address 7: error pulse, nothing changes after a commit.
    applyStimulus(1'b1, 3'd7, COEF_W'(1), 1'b0, 1'b1, "badaddr");
    checkOutput("err_pulse", longint'(err_o[0]), 1);
    applyStimulus(1'b0, 3'd0, '0, 1'b1, 1'b1, "badcommit");
    settle(8, "badapply");
    checkOutput("bad_no_change", longint'($signed(coef_o[0][5])), 6);

    // Second commit during MUTE is dropped.
    applyStimulus(1'b1, 3'd0, COEF_W'(100), 1'b0, 1'b1, "wr100");
    clearCounts();
    applyStimulus(1'b0, 3'd0, '0, 1'b1, 1'b1, "commitA");
    applyStimulus(1'b0, 3'd0, '0, 1'b1, 1'b1, "commitB");
    settle(10, "double");
    checkOutput("double_busy_mute", busyCount[0], 6);
    checkOutput("double_busy_nomute", busyCount[1], 2);
    checkOutput("double_coef0", longint'($signed(coef_o[0][0])), 100);

    // Write and commit in the same cycle.
    applyStimulus(1'b1, ADDR_B0_PD, -COEF_W'(5), 1'b1, 1'b1, "wrcommit");
    settle(8, "wrcommit_apply");
    checkOutput("same_cycle_b0pd_mute", longint'($signed(coef_o[0][4])), -5);
    checkOutput("same_cycle_b0pd_nomute", longint'($signed(coef_o[1][4])), -5);

    // Reset during MUTE aborts the commit.
    applyStimulus(1'b1, 3'd1, COEF_W'(77), 1'b0, 1'b1, "prerst");
    applyStimulus(1'b0, 3'd0, '0, 1'b1, 1'b1, "rstcommit");
    settle(2, "inmute");
    rst_n = 1'b0;
    #1;
    modelReset();
    compareAll("async_rst");
    checkOutput("rst_coef2", longint'($signed(coef_o[0][2])), 0);
    settle(2, "inrst");
    rst_n = 1'b1;
    applyStimulus(1'b0, 3'd0, '0, 1'b0, 1'b0, "en0");
    applyStimulus(1'b0, 3'd0, '0, 1'b0, 1'b1, "en1");
    checkOutput("on_after_rst", longint'(on_o[0]), 1);
    settle(8, "postrst");
    checkOutput("aborted_coef1", longint'($signed(coef_o[0][1])), 0);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 1'b0;
        #1;
        modelReset();
        compareAll("rnd_rst");
      end else begin
        rst_n = 1'b1;
      end
`ifdef SERVO_COEF_READBACK_EN
      rd_addr = 3'($urandom_range(0, 7));
`endif
      applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                    COEF_W'({$urandom(), $urandom()}),
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) != 0), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
